// File: rtl/proc_clk_pkg.sv
// Shared defaults for the processor clock controller and its divider.
package proc_clk_pkg;

   localparam int unsigned DEFAULT_DIV       = 4;
   localparam int unsigned DEFAULT_NUM_STALL = 2;
   localparam int unsigned DEFAULT_TIMEOUT_W = 16;
   localparam int unsigned DEFAULT_CNT_W     = 32;

endpackage

// File: rtl/clk_divider.sv
// Divides clk by DIV into a 50% duty registered clk_sys.
// Also provides one-cycle strobes marking the clk edges where clk_sys rises/falls.
module clk_divider
   import proc_clk_pkg::*;
#(
   parameter int unsigned DIV = DEFAULT_DIV
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic clk_sys_o,
   output logic rise_c_o,
   output logic fall_c_o
);

   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

   if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
      $error("clk_divider: DIV must be even and >= 2");
   end

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          clk_sys_q, clk_sys_d;
   logic          wrap_c;

   // Half-period counter; clk_sys toggles on each wrap.
   always_comb begin
      wrap_c    = (div_cnt_q == DW'(HALF - 1));
      div_cnt_d = wrap_c ? '0 : div_cnt_q + DW'(1);
      clk_sys_d = clk_sys_q ^ wrap_c;
      rise_c_o  = wrap_c & ~clk_sys_q;
      fall_c_o  = wrap_c & clk_sys_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt_q <= '0;
         clk_sys_q <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         clk_sys_q <= clk_sys_d;
      end
   end

   assign clk_sys_o = clk_sys_q;

endmodule

// File: rtl/proc_clk_ctrl.sv
// Processor clock controller: divided clk_sys, stall-gated clk_proc, stall watchdog.
// Optional stall_cycles performance counter enabled by `define STALL_PERF_CNT_EN.
module proc_clk_ctrl
   import proc_clk_pkg::*;
#(
   parameter int unsigned DIV       = DEFAULT_DIV,
   parameter int unsigned NUM_STALL = DEFAULT_NUM_STALL,
   parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W,
   parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_STALL-1:0] stall_req,
   input  logic [NUM_STALL-1:0] stall_mask,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 timeout_clr,
   output logic                 clk_sys,
   output logic                 clk_proc,
   output logic                 stall_active,
   output logic [NUM_STALL-1:0] stall_src,
   output logic                 timeout,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam int unsigned TW1 = TIMEOUT_W + 1;

   logic                 rise_c, fall_c;
   logic [NUM_STALL-1:0] eff_c;
   logic                 any_c, hit_c;
   logic [TW1-1:0]       timer_inc_c;

   logic                 gate_q, gate_d;
   logic [TIMEOUT_W-1:0] timer_q, timer_d;
   logic [NUM_STALL-1:0] src_q, src_d;
   logic                 timeout_q, timeout_d;
   logic                 clk_proc_q, clk_proc_d;

   clk_divider #(.DIV(DIV)) u_div (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clk_sys_o (clk_sys),
      .rise_c_o  (rise_c),
      .fall_c_o  (fall_c)
   );

   // Stall requests are only looked at on clk_sys falls, so mid-period changes are invisible.
   always_comb begin
      eff_c       = stall_req & ~stall_mask;
      any_c       = |eff_c;
      timer_inc_c = {1'b0, timer_q} + TW1'(1);
      hit_c       = gate_q && (timeout_limit != '0) && (timer_inc_c == {1'b0, timeout_limit});

      gate_d    = gate_q;
      timer_d   = timer_q;
      src_d     = src_q;
      timeout_d = timeout_q;

      if (timeout_clr) timeout_d = 1'b0;

      if (fall_c) begin
         gate_d = any_c & ~timeout_q & ~hit_c;
         src_d  = eff_c;
         if (gate_q) timer_d = (&timer_q) ? timer_q : timer_inc_c[TIMEOUT_W-1:0];
         else        timer_d = '0;
         if (hit_c)  timeout_d = 1'b1;
      end

      // Equivalent to next_clk_sys | next_gate: rises follow clk_sys, falls follow the new gate.
      if (rise_c)      clk_proc_d = 1'b1;
      else if (fall_c) clk_proc_d = gate_d;
      else             clk_proc_d = clk_proc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q     <= 1'b0;
         timer_q    <= '0;
         src_q      <= '0;
         timeout_q  <= 1'b0;
         clk_proc_q <= 1'b0;
      end else begin
         gate_q     <= gate_d;
         timer_q    <= timer_d;
         src_q      <= src_d;
         timeout_q  <= timeout_d;
         clk_proc_q <= clk_proc_d;
      end
   end

   assign clk_proc     = clk_proc_q;
   assign stall_active = gate_q;
   assign stall_src    = src_q;
   assign timeout      = timeout_q;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] perf_q, perf_d;

   // Counts clk_proc rises swallowed by the gate; saturating.
   always_comb begin
      perf_d = perf_q;
      if (rise_c && gate_q && !(&perf_q)) perf_d = perf_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign stall_cycles = perf_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
